// File: rtl/mbist_march_ctrl.sv
// MBIST controller running March C- over one SRAM with one or two data
// backgrounds. Owns the address/op sequencer, the expected-data compare
// pipeline and sticky fail reporting. NbarT hands the SRAM to the test path.
module mbist_march_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int NUM_BG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              NbarT,
  output logic              ld,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        fail_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Sequencer position: background, march element (0..5), op within element, address
  logic              bg;
  logic [2:0]        elem;
  logic              opi;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        drain_cnt;

  logic              is_read;
  logic              two_op;
  logic              elem_last_op;
  logic              is_down;
  logic              addr_last;
  logic              bg_last;
  logic              last_op;
  logic [DATA_W-1:0] bg_pat;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] wr_data;

  // Compare pipeline: one stage per clock of read latency
  logic [RD_LAT-1:0] pv;
  logic [ADDR_W-1:0] pa [RD_LAT];
  logic [DATA_W-1:0] pe [RD_LAT];

  // Decode the current op from the sequencer position
  always_comb begin
    bg_pat = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      bg_pat[i] = bg && (i % 2 == 0);
    end
    two_op       = (elem != 3'd0) && (elem != 3'd5);
    is_read      = (elem == 3'd5) || ((elem != 3'd0) && !opi);
    elem_last_op = !two_op || opi;
    is_down      = (elem >= 3'd3);
    addr_last    = is_down ? (addr == '0) : (addr == '1);
    bg_last      = (NUM_BG == 1) || bg;
    last_op      = elem_last_op && addr_last && (elem == 3'd5) && bg_last;
    // M2/M4 read the inverse background; M1/M3 write it
    exp_data     = ((elem == 3'd2) || (elem == 3'd4)) ? ~bg_pat : bg_pat;
    wr_data      = ((elem == 3'd1) || (elem == 3'd3)) ? ~bg_pat : bg_pat;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort takes priority over everything else
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !abort) state_nxt = S_SETUP;
      S_SETUP: state_nxt = abort ? S_IDLE : S_RUN;
      S_RUN:   if (abort) state_nxt = S_IDLE;
               else if (last_op) state_nxt = S_DRAIN;
      S_DRAIN: if (abort) state_nxt = S_IDLE;
               else if (drain_cnt == 2'(RD_LAT - 1)) state_nxt = S_DONE;
      S_DONE:  if (abort) state_nxt = S_IDLE;
               else if (start) state_nxt = S_SETUP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Drain counter: counts the RD_LAT clocks spent in DRAIN
  always_ff @(posedge clk) begin
    if (rst || state != S_DRAIN) drain_cnt <= '0;
    else                         drain_cnt <= drain_cnt + 2'd1;
  end

  // Op/address sequencer: ops at one address first, then step; wrap only at element end
  always_ff @(posedge clk) begin
    if (rst || state == S_SETUP) begin
      bg   <= 1'b0;
      elem <= 3'd0;
      opi  <= 1'b0;
      addr <= '0;
    end else if (state == S_RUN && !abort) begin
      if (!elem_last_op) begin
        opi <= 1'b1;
      end else begin
        opi <= 1'b0;
        if (!addr_last) begin
          addr <= is_down ? addr - 1'b1 : addr + 1'b1;
        end else begin
          // Next element starts at the top for M3..M5, at zero otherwise
          addr <= ((elem == 3'd2) || (elem == 3'd3) || (elem == 3'd4)) ? '1 : '0;
          if (elem == 3'd5) begin
            elem <= 3'd0;
            if (!bg_last) bg <= 1'b1;
          end else begin
            elem <= elem + 3'd1;
          end
        end
      end
    end
  end

  // Compare pipeline valids; cleared by SETUP or abort so stale reads never compare
  always_ff @(posedge clk) begin
    if (rst || abort || state == S_SETUP) begin
      pv <= '0;
    end else begin
      pv[0] <= mem_re;
      for (int unsigned i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
    end
  end

  // Compare pipeline payload: address and expected data of each read
  always_ff @(posedge clk) begin
    pa[0] <= addr;
    pe[0] <= exp_data;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pa[i] <= pa[i-1];
      pe[i] <= pe[i-1];
    end
  end

  // Sticky fail reporting at the pipeline tap; first failing address is kept
  always_ff @(posedge clk) begin
    if (rst || (state == S_SETUP && !abort)) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else if (pv[RD_LAT-1] && !abort && (mem_rdata != pe[RD_LAT-1])) begin
      fail <= 1'b1;
      if (!fail) fail_addr <= pa[RD_LAT-1];
      if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
    end
  end

  // Status and SRAM-side outputs; memory strobes only in RUN
  always_comb begin
    busy      = (state == S_SETUP) || (state == S_RUN) || (state == S_DRAIN);
    NbarT     = busy;
    ld        = (state == S_IDLE) || (state == S_SETUP);
    done      = (state == S_DONE);
    mem_we    = (state == S_RUN) && !is_read;
    mem_re    = (state == S_RUN) && is_read;
    mem_addr  = (state == S_RUN) ? addr : '0;
    mem_wdata = mem_we ? wr_data : '0;
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: three instances (1 bg/lat 1, 2 bg/lat 1,
// 1 bg/lat 3) on 4-word SRAM models, op stream checked against a queue of
// expected march ops built independently, plus latency and fail checks.
module tb_mbist_march_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic       nbart1, ld1, we1, re1, busy1, done1, fail1;
  logic [1:0] a1, fa1;
  logic [7:0] wd1, fc1, rd1;
  logic       nbart2, ld2, we2, re2, busy2, done2, fail2;
  logic [1:0] a2, fa2;
  logic [7:0] wd2, fc2, rd2;
  logic       nbart3, ld3, we3, re3, busy3, done3, fail3;
  logic [1:0] a3, fa3;
  logic [7:0] wd3, fc3, rd3;

  logic [7:0]  m1 [4];
  logic [7:0]  m2 [4];
  logic [7:0]  m3 [4];
  logic [7:0]  p3a, p3b;
  logic        fault1 = 1'b0;
  logic        fault3 = 1'b0;

  logic [11:0] q1 [$];
  logic [11:0] q2 [$];
  logic [11:0] q3 [$];
  logic [11:0] tq [$];

  int n_tests = 0;
  int n_fail  = 0;
  int t1, t2, t3;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.ADDR_W(2), .DATA_W(8), .RD_LAT(1), .NUM_BG(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_rdata(rd1),
    .NbarT(nbart1), .ld(ld1), .mem_addr(a1), .mem_wdata(wd1), .mem_we(we1),
    .mem_re(re1), .busy(busy1), .done(done1), .fail(fail1), .fail_addr(fa1),
    .fail_count(fc1));

  mbist_march_ctrl #(.ADDR_W(2), .DATA_W(8), .RD_LAT(1), .NUM_BG(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_rdata(rd2),
    .NbarT(nbart2), .ld(ld2), .mem_addr(a2), .mem_wdata(wd2), .mem_we(we2),
    .mem_re(re2), .busy(busy2), .done(done2), .fail(fail2), .fail_addr(fa2),
    .fail_count(fc2));

  mbist_march_ctrl #(.ADDR_W(2), .DATA_W(8), .RD_LAT(3), .NUM_BG(1)) u3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_rdata(rd3),
    .NbarT(nbart3), .ld(ld3), .mem_addr(a3), .mem_wdata(wd3), .mem_we(we3),
    .mem_re(re3), .busy(busy3), .done(done3), .fail(fail3), .fail_addr(fa3),
    .fail_count(fc3));

  // SRAM models; optional bit-3 stuck-at-1 at address 2 on u1/u3
  always @(posedge clk) begin
    if (we1) m1[a1] <= wd1;
    rd1 <= m1[a1] | ((fault1 && a1 == 2'd2) ? 8'h08 : 8'h00);
    if (we2) m2[a2] <= wd2;
    rd2 <= m2[a2];
    if (we3) m3[a3] <= wd3;
    p3a <= m3[a3] | ((fault3 && a3 == 2'd2) ? 8'h08 : 8'h00);
    p3b <= p3a;
    rd3 <= p3b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(input logic we, input int a, input logic [7:0] d);
    return {we, ~we, 2'(a), we ? d : 8'h00};
  endfunction

  // Expected op stream: March C- per background, listed element by element
  task automatic build(input int nbg);
    logic [7:0] b;
    tq.delete();
    for (int g = 0; g < nbg; g++) begin
      b = (g == 0) ? 8'h00 : 8'h55;
      for (int a = 0; a < 4; a++) tq.push_back(pk(1'b1, a, b));
      for (int a = 0; a < 4; a++) begin tq.push_back(pk(1'b0, a, b)); tq.push_back(pk(1'b1, a, ~b)); end
      for (int a = 0; a < 4; a++) begin tq.push_back(pk(1'b0, a, b)); tq.push_back(pk(1'b1, a, b)); end
      for (int a = 3; a >= 0; a--) begin tq.push_back(pk(1'b0, a, b)); tq.push_back(pk(1'b1, a, ~b)); end
      for (int a = 3; a >= 0; a--) begin tq.push_back(pk(1'b0, a, b)); tq.push_back(pk(1'b1, a, b)); end
      for (int a = 3; a >= 0; a--) tq.push_back(pk(1'b0, a, b));
    end
  endtask

  // Scoreboard: every memory op popped against the expected queue
  always @(negedge clk) begin
    if (we1 || re1) begin
      if (q1.size() == 0) chk("u1_extra_op", {30'd0, we1, re1}, 32'd0);
      else chk("u1_op", {20'd0, we1, re1, a1, we1 ? wd1 : 8'h00}, {20'd0, q1.pop_front()});
    end
    if (we2 || re2) begin
      if (q2.size() == 0) chk("u2_extra_op", {30'd0, we2, re2}, 32'd0);
      else chk("u2_op", {20'd0, we2, re2, a2, we2 ? wd2 : 8'h00}, {20'd0, q2.pop_front()});
    end
    if (we3 || re3) begin
      if (q3.size() == 0) chk("u3_extra_op", {30'd0, we3, re3}, 32'd0);
      else chk("u3_op", {20'd0, we3, re3, a3, we3 ? wd3 : 8'h00}, {20'd0, q3.pop_front()});
    end
  end

  task automatic check_reset();
    chk("rst_ld", ld1, 1);
    chk("rst_nbart", nbart1, 0);
    chk("rst_addr", a1, 0);
    chk("rst_wdata", wd1, 0);
    chk("rst_we", we1, 0);
    chk("rst_re", re1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_fail", fail1, 0);
    chk("rst_fail_addr", fa1, 0);
    chk("rst_fail_count", fc1, 0);
    chk("rst_busy_u2", busy2, 0);
  endtask

  // One run: start pulse, optional abort / rst / extra start at given cycle.
  // Cycle 1 is the negedge right after the edge that samples start.
  task automatic do_run(input int abort_at, input int rst_at, input int poke_at);
    build(1); q1 = tq; q3 = tq;
    build(2); q2 = tq;
    t1 = 0; t2 = 0; t3 = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk);
      start = (cyc == poke_at);
      if (cyc == 1) begin
        chk("setup_busy", busy1, 1);
        chk("setup_done", done1, 0);
        chk("setup_ld", ld1, 1);
      end
      if (cyc == 2) begin
        chk("setup_fail_clr", fail1, 0);
        chk("setup_fcnt_clr", fc1, 0);
        chk("setup_faddr_clr", fa1, 0);
      end
      if (done1 && t1 == 0) t1 = cyc;
      if (done2 && t2 == 0) t2 = cyc;
      if (done3 && t3 == 0) t3 = cyc;
      if (abort_at > 0 && cyc == abort_at) abort = 1'b1;
      if (abort_at > 0 && cyc == abort_at + 1) begin
        abort = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_nbart", nbart1, 0);
        chk("abort_done", done1, 0);
        chk("abort_ld", ld1, 1);
        chk("abort_busy_u3", busy3, 0);
        q1.delete(); q2.delete(); q3.delete();
      end
      if (rst_at > 0 && cyc == rst_at) begin
        chk("pre_rst_fail", fail1, 1);
        rst = 1'b1;
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        rst = 1'b0;
        check_reset();
        q1.delete(); q2.delete(); q3.delete();
      end
      if ((abort_at > 0 && cyc == abort_at + 12) || (rst_at > 0 && cyc == rst_at + 12)) break;
      if (t1 != 0 && t2 != 0 && t3 != 0) break;
    end
    start = 1'b0;
  endtask

  task automatic check_clean_done(input string run);
    chk({run, "_lat_u1"}, t1, 43);
    chk({run, "_lat_u2"}, t2, 83);
    chk({run, "_lat_u3"}, t3, 45);
    chk({run, "_fail_u1"}, fail1, 0);
    chk({run, "_fcnt_u1"}, fc1, 0);
    chk({run, "_fail_u2"}, fail2, 0);
    chk({run, "_fail_u3"}, fail3, 0);
    chk({run, "_ops_left_u1"}, q1.size(), 0);
    chk({run, "_ops_left_u2"}, q2.size(), 0);
    chk({run, "_ops_left_u3"}, q3.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;

    // start together with abort in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy1, 0);
    chk("start_abort_ld", ld1, 1);

    // clean run on all three configurations
    do_run(0, 0, 0);
    check_clean_done("runA");

    // stuck-at fault on u1/u3, restart from DONE, start pulsed mid-run is ignored
    fault1 = 1'b1; fault3 = 1'b1;
    do_run(0, 0, 20);
    chk("runB_lat_u1", t1, 43);
    chk("runB_lat_u2", t2, 83);
    chk("runB_lat_u3", t3, 45);
    chk("runB_fail_u1", fail1, 1);
    chk("runB_faddr_u1", fa1, 2);
    chk("runB_fcnt_u1", fc1, 3);
    chk("runB_fail_u3", fail3, 1);
    chk("runB_faddr_u3", fa3, 2);
    chk("runB_fcnt_u3", fc3, 3);
    chk("runB_fail_u2", fail2, 0);
    chk("runB_done_held", done1, 1);

    // restart on a healed SRAM: SETUP clears the fail fields
    fault1 = 1'b0; fault3 = 1'b0;
    do_run(0, 0, 0);
    check_clean_done("runC");

    // abort from DONE
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("done_abort_done", done1, 0);
    chk("done_abort_ld", ld1, 1);

    // abort in RUN clock 10, then no further memory ops
    do_run(11, 0, 0);
    chk("runD_done", done1, 0);

    // rst mid-run after a mismatch has been recorded
    fault1 = 1'b1;
    do_run(0, 16, 0);
    chk("runE_fail_after_rst", fail1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
